// File: rtl/intc_pkg.sv
// intc_pkg: register map, source modes and FSM encodings shared by the interrupt controller.
package intc_pkg;
  localparam int DEV_ADDR_WD = 4;
  localparam logic [DEV_ADDR_WD-1:0] INTC_REG_MASK = 4'h0;
  localparam logic [DEV_ADDR_WD-1:0] INTC_REG_MODE = 4'h1;
  localparam logic [DEV_ADDR_WD-1:0] INTC_REG_PEND = 4'h2;
  localparam logic [DEV_ADDR_WD-1:0] INTC_REG_ISR  = 4'h3;
  localparam logic INTC_MODE_LEVEL = 1'b0;
  localparam logic INTC_MODE_EDGE  = 1'b1;
  localparam int INTC_SRC_TC = 2;
  typedef enum logic [1:0] {
    INTC_ST_IDLE    = 2'd0,
    INTC_ST_REQ     = 2'd1,
    INTC_ST_SERVICE = 2'd2
  } intc_st_e;
endpackage

// File: rtl/intc_prio.sv
// intc_prio: lowest-index-wins priority encoder over the eligible sources.
module intc_prio #(
  parameter int NUM_SRC = 6
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [2:0]         idx_o,
  output logic               vld_o
);
  always_comb begin
    idx_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) idx_o = req_i[i] ? i[2:0] : idx_o;
  end
  assign vld_o = |req_i;
endmodule

// File: rtl/intc.sv
// intc: latches, masks and prioritises interrupt sources and tracks one in-service
// interrupt through an ack / end-of-interrupt handshake toward CP0.
module intc
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   we_i,
  input  logic [DEV_ADDR_WD-1:0] add_i,
  input  logic [31:0]            dat_i,
  output logic [31:0]            dat_o,
  input  logic [NUM_SRC-1:0]     irq_src_i,
  output logic                   int_req_o,
  output logic [2:0]             int_id_o,
  input  logic                   int_ack_i,
  input  logic                   int_eoi_i
);
  intc_st_e state_q, state_d;
  logic [NUM_SRC-1:0] mask_q, mode_q, pend_q, pend_d, prev_q, isr_q, isr_d;
  logic [NUM_SRC-1:0] elig, edge_set, w1c, ack_clr;
  logic [2:0] id_q, id_d, best;
  logic req_q, req_d, best_vld, ack_take, eoi_take;
  logic wr_mask, wr_mode, wr_pend, unused_dat;
  assign wr_mask = we_i && (add_i == INTC_REG_MASK);
  assign wr_mode = we_i && (add_i == INTC_REG_MODE);
  assign wr_pend = we_i && (add_i == INTC_REG_PEND);
  assign ack_take = (state_q == INTC_ST_REQ) && int_ack_i;
  assign eoi_take = (state_q == INTC_ST_SERVICE) && int_eoi_i;
  assign edge_set = irq_src_i & ~prev_q;
  assign w1c = wr_pend ? dat_i[NUM_SRC-1:0] : '0;
  assign ack_clr = ack_take ? (NUM_SRC'(1) << id_q) : '0;
  // No nesting: any in-service source blocks every request.
  assign elig = (|isr_q) ? '0 : (pend_q & mask_q);
  assign unused_dat = ^dat_i[31:NUM_SRC];
  intc_prio #(.NUM_SRC(NUM_SRC)) u_prio (
    .req_i(elig),
    .idx_o(best),
    .vld_o(best_vld)
  );
  // A new edge beats a same-cycle W1C or ack clear.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_SRC; i++)
      pend_d[i] = (mode_q[i] == INTC_MODE_EDGE) ? (edge_set[i] | (pend_q[i] & ~w1c[i] & ~ack_clr[i]))
                                                : irq_src_i[i];
  end
  always_comb begin
    state_d = (state_q == INTC_ST_IDLE)    ? (best_vld ? INTC_ST_REQ : INTC_ST_IDLE) :
              (state_q == INTC_ST_REQ)     ? (int_ack_i ? INTC_ST_SERVICE : best_vld ? INTC_ST_REQ : INTC_ST_IDLE) :
              (state_q == INTC_ST_SERVICE) ? (int_eoi_i ? INTC_ST_IDLE : INTC_ST_SERVICE) :
                                             INTC_ST_IDLE;
  end
  always_comb begin
    req_d = (state_d == INTC_ST_REQ);
    id_d  = req_d ? best : id_q;
    isr_d = ack_take ? (NUM_SRC'(1) << id_q) : eoi_take ? '0 : isr_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= INTC_ST_IDLE;
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      isr_q   <= '0;
      req_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= wr_mask ? dat_i[NUM_SRC-1:0] : mask_q;
      mode_q  <= wr_mode ? dat_i[NUM_SRC-1:0] : mode_q;
      pend_q  <= pend_d;
      prev_q  <= irq_src_i;
      isr_q   <= isr_d;
      req_q   <= req_d;
      id_q    <= id_d;
    end
  end
  always_comb begin
    dat_o = (add_i == INTC_REG_MASK) ? 32'(mask_q) :
            (add_i == INTC_REG_MODE) ? 32'(mode_q) :
            (add_i == INTC_REG_PEND) ? 32'(pend_q) :
            (add_i == INTC_REG_ISR)  ? 32'(isr_q)  : 32'h0;
  end
  assign int_req_o = req_q;
  assign int_id_o  = id_q;
endmodule

// File: tb/tb_intc.sv
// tb_intc: directed test-plan sequences plus random traffic, scored against a behavioural model.
module tb_intc;
  import intc_pkg::*;
  localparam int N = 6;
  localparam int ST_IDLE = 0, ST_REQ = 1, ST_SVC = 2;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic we_i = 1'b0;
  logic [DEV_ADDR_WD-1:0] add_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [N-1:0] irq_src_i = '0;
  logic int_req_o;
  logic [2:0] int_id_o;
  logic int_ack_i = 1'b0;
  logic int_eoi_i = 1'b0;
  logic [N-1:0] src = '0;
  typedef struct {
    logic       req;
    logic [2:0] id;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0;
  bit [N-1:0] m_mask, m_mode, m_pend, m_prev;
  int m_svc, m_st, m_id;
  bit m_req;

  intc #(.NUM_SRC(N)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .we_i(we_i), .add_i(add_i), .dat_i(dat_i),
    .dat_o(dat_o), .irq_src_i(irq_src_i), .int_req_o(int_req_o), .int_id_o(int_id_o),
    .int_ack_i(int_ack_i), .int_eoi_i(int_eoi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '0;
    m_svc = -1; m_st = ST_IDLE; m_id = 0; m_req = 0;
  endtask

  function automatic logic [31:0] m_read(logic [DEV_ADDR_WD-1:0] a);
    if (a == INTC_REG_MASK) return 32'(m_mask);
    if (a == INTC_REG_MODE) return 32'(m_mode);
    if (a == INTC_REG_PEND) return 32'(m_pend);
    if (a == INTC_REG_ISR) return (m_svc < 0) ? 32'h0 : (32'(1) << m_svc);
    return 32'h0;
  endfunction

  // One clock edge of the controller as described by its rules, using the inputs now applied.
  task automatic m_step();
    bit [N-1:0] elig, np;
    int best;
    bit ack_ok;
    best = -1;
    elig = (m_svc >= 0) ? '0 : (m_pend & m_mask);
    for (int i = 0; i < N; i++) if (elig[i] && best < 0) best = i;
    ack_ok = (m_st == ST_REQ) && int_ack_i;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) begin
        np[i] = m_pend[i];
        if (we_i && add_i == INTC_REG_PEND && dat_i[i]) np[i] = 1'b0;
        if (ack_ok && m_id == i) np[i] = 1'b0;
        if (irq_src_i[i] && !m_prev[i]) np[i] = 1'b1;
      end else np[i] = irq_src_i[i];
    end
    case (m_st)
      ST_IDLE: begin
        if (best >= 0) begin m_st = ST_REQ; m_req = 1; m_id = best; end
      end
      ST_REQ: begin
        if (int_ack_i) begin m_st = ST_SVC; m_req = 0; m_svc = m_id; end
        else if (best < 0) begin m_st = ST_IDLE; m_req = 0; end
        else m_id = best;
      end
      default: begin
        if (int_eoi_i) begin m_st = ST_IDLE; m_svc = -1; end
      end
    endcase
    if (we_i && add_i == INTC_REG_MASK) m_mask = dat_i[N-1:0];
    if (we_i && add_i == INTC_REG_MODE) m_mode = dat_i[N-1:0];
    m_pend = np;
    m_prev = irq_src_i;
  endtask

  task automatic cyc(bit we, logic [DEV_ADDR_WD-1:0] a, logic [31:0] d, bit ack, bit eoi);
    @(negedge clk_i);
    we_i = we; add_i = a; dat_i = d; int_ack_i = ack; int_eoi_i = eoi; irq_src_i = src;
    @(posedge clk_i);
    m_step();
    sb.push_back('{m_req, 3'(m_id), m_read(add_i)});
  endtask

  task automatic rd(logic [DEV_ADDR_WD-1:0] a);  cyc(1'b0, a, 32'h0, 1'b0, 1'b0); endtask
  task automatic wr(logic [DEV_ADDR_WD-1:0] a, logic [31:0] d); cyc(1'b1, a, d, 1'b0, 1'b0); endtask
  task automatic ack(logic [DEV_ADDR_WD-1:0] a); cyc(1'b0, a, 32'h0, 1'b1, 1'b0); endtask
  task automatic eoi(logic [DEV_ADDR_WD-1:0] a); cyc(1'b0, a, 32'h0, 1'b0, 1'b1); endtask

  always @(posedge clk_i) begin
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_req", 32'(int_req_o), 32'(e.req));
      check("sb_id", 32'(int_id_o), 32'(e.id));
      check("sb_dat", dat_o, e.dat);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    #2;
    check("rst_req", 32'(int_req_o), 0);
    check("rst_id", 32'(int_id_o), 0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(DEV_ADDR_WD'(a));
      #2 check("rst_reg", dat_o, 0);
    end
    // level mode, TC line held high
    wr(INTC_REG_MASK, 32'h3F);
    src = N'(1) << INTC_SRC_TC;
    rd(INTC_REG_PEND);
    #2 check("lvl_pend", dat_o, 32'h04); check("lvl_req_early", 32'(int_req_o), 0);
    rd(INTC_REG_ISR);
    #2 check("lvl_req", 32'(int_req_o), 1); check("lvl_id", 32'(int_id_o), 2);
    ack(INTC_REG_ISR);
    #2 check("lvl_ack_req", 32'(int_req_o), 0); check("lvl_isr", dat_o, 32'h04);
    eoi(INTC_REG_ISR);
    #2 check("lvl_eoi_isr", dat_o, 0); check("lvl_eoi_req", 32'(int_req_o), 0);
    rd(INTC_REG_ISR);
    #2 check("lvl_rereq", 32'(int_req_o), 1); check("lvl_reid", 32'(int_id_o), 2);
    ack(INTC_REG_ISR);
    src = '0;
    eoi(INTC_REG_ISR);
    rd(INTC_REG_PEND);
    #2 check("lvl_idle", 32'(int_req_o), 0);
    // edge mode with pre-emption before the ack
    wr(INTC_REG_MODE, 32'h3F);
    src = 6'h20;
    rd(INTC_REG_PEND);
    #2 check("edg_pend5", dat_o, 32'h20);
    src = '0;
    rd(INTC_REG_PEND);
    #2 check("edg_req5", 32'(int_req_o), 1); check("edg_id5", 32'(int_id_o), 5);
    src = 6'h02;
    rd(INTC_REG_PEND);
    #2 check("edg_pend51", dat_o, 32'h22);
    src = '0;
    rd(INTC_REG_PEND);
    #2 check("edg_preempt", 32'(int_id_o), 1);
    ack(INTC_REG_PEND);
    #2 check("edg_ack_pend", dat_o, 32'h20); check("edg_ack_req", 32'(int_req_o), 0);
    rd(INTC_REG_ISR);
    #2 check("edg_isr", dat_o, 32'h02);
    eoi(INTC_REG_ISR);
    rd(INTC_REG_ISR);
    #2 check("edg_next", 32'(int_id_o), 5); check("edg_next_req", 32'(int_req_o), 1);
    ack(INTC_REG_PEND);
    #2 check("edg_pend_clr", dat_o, 0);
    eoi(INTC_REG_ISR);
    // masked edge source, W1C and W1C colliding with a new edge
    wr(INTC_REG_MASK, 32'h37);
    src = 6'h08;
    rd(INTC_REG_PEND);
    src = '0;
    rd(INTC_REG_PEND);
    rd(INTC_REG_PEND);
    #2 check("msk_req", 32'(int_req_o), 0); check("msk_pend", dat_o, 32'h08);
    wr(INTC_REG_PEND, 32'h08);
    #2 check("w1c_pend", dat_o, 0);
    src = 6'h08;
    wr(INTC_REG_PEND, 32'h08);
    #2 check("w1c_setwins", dat_o, 32'h08);
    src = '0;
    // stray ack / eoi, then ack+eoi together
    ack(INTC_REG_ISR);
    #2 check("ack_idle", 32'(int_req_o), 0);
    wr(INTC_REG_MASK, 32'h3F);
    rd(INTC_REG_ISR);
    #2 check("req3", 32'(int_req_o), 1); check("id3", 32'(int_id_o), 3);
    eoi(INTC_REG_ISR);
    #2 check("eoi_req_kept", 32'(int_req_o), 1); check("eoi_req_isr", dat_o, 0);
    cyc(1'b0, INTC_REG_ISR, 32'h0, 1'b1, 1'b1);
    #2 check("ackeoi_req", 32'(int_req_o), 0); check("ackeoi_isr", dat_o, 32'h08);
    // asynchronous reset in SERVICE
    #3 rst_n_i = 1'b0;
    #1 check("arst_req", 32'(int_req_o), 0); check("arst_id", 32'(int_id_o), 0);
    check("arst_isr", dat_o, 0);
    m_reset();
    add_i = INTC_REG_MASK;
    #1 check("arst_mask", dat_o, 0);
    add_i = INTC_REG_MODE;
    #1 check("arst_mode", dat_o, 0);
    add_i = INTC_REG_PEND;
    #1 check("arst_pend", dat_o, 0);
    @(negedge clk_i) rst_n_i = 1'b1;
    rd(INTC_REG_PEND);
    #2 check("arst_idle", 32'(int_req_o), 0);
    // random traffic
    wr(INTC_REG_MASK, $urandom);
    wr(INTC_REG_MODE, $urandom);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(2) == 0) src = src ^ N'($urandom);
      cyc($urandom_range(7) == 0, DEV_ADDR_WD'($urandom_range(4)), $urandom,
          $urandom_range(2) == 0, $urandom_range(3) == 0);
    end
    repeat (3) @(posedge clk_i);
    #2 check("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
